mips_multicycle_ctrl: RTL and testbench

//  Main control FSM for the multi-cycle mips_core datapath. It sequences fetch, decode,

---
 rtl/mips_multicycle_ctrl_pkg.sv | 70 +++++++
 rtl/mips_multicycle_ctrl_if.sv | 35 +++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 63 ++++++
 rtl/mips_multicycle_ctrl.sv | 136 +++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

  localparam int ALU_W = 4;

  // Control states; the numeric value is exported on state_dbg.
  typedef enum logic [3:0] {
    RST_IDLE = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    WB_R     = 4'd4,
    EXEC_I   = 4'd5,
    WB_I     = 4'd6,
    MEM_ADR  = 4'd7,
    MEM_RD   = 4'd8,
    WB_MEM   = 4'd9,
    MEM_WR   = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SLL = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SRL = 4'b1001;

  // Datapath mux selects
  localparam logic [1:0] SRCA_PC      = 2'd0;
  localparam logic [1:0] SRCA_RS      = 2'd1;
  localparam logic [1:0] SRCA_SHAMT   = 2'd2;
  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // Shifts take their A operand from the shamt field instead of rs.
  function automatic logic is_shift(input logic [5:0] funct);
    return (funct == F_SLL) || (funct == F_SRL);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multi-cycle controller (master) and the datapath (slave).
interface mips_multicycle_ctrl_if;
  import mips_ctrl_pkg::*;

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             mem_ready;
  logic             pc_en;
  logic [1:0]       pc_src;
  logic             iord;
  logic             mem_rd;
  logic             mem_wr;
  logic             ir_write;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [ALU_W-1:0] alu_ctrl;
  logic             illegal_instr;
  logic [3:0]       state_dbg;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output pc_en, pc_src, iord, mem_rd, mem_wr, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, illegal_instr, state_dbg
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  pc_en, pc_src, iord, mem_rd, mem_wr, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, illegal_instr, state_dbg
  );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation select and instruction legality check.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t           state,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic             legal
);

  logic [ALU_W-1:0] r_ctrl;
  logic [ALU_W-1:0] i_ctrl;
  logic             r_ok;
  logic             i_ok;

  // Map funct (R-type) and opcode (I-type) to ALU operations and flag supported encodings.
  always_comb begin
    r_ctrl = ALU_AND;
    r_ok   = 1'b1;
    case (funct)
      F_ADD:   r_ctrl = ALU_ADD;
      F_SUB:   r_ctrl = ALU_SUB;
      F_AND:   r_ctrl = ALU_AND;
      F_OR:    r_ctrl = ALU_OR;
      F_SLT:   r_ctrl = ALU_SLT;
      F_SLL:   r_ctrl = ALU_SLL;
      F_SRL:   r_ctrl = ALU_SRL;
      default: r_ok   = 1'b0;
    endcase

    i_ctrl = ALU_ADD;
    i_ok   = 1'b1;
    case (opcode)
      OP_ADDI: i_ctrl = ALU_ADD;
      OP_ANDI: i_ctrl = ALU_AND;
      OP_ORI:  i_ctrl = ALU_OR;
      OP_SLTI: i_ctrl = ALU_SLT;
      default: i_ok   = 1'b0;
    endcase
  end

  // An instruction is legal if its opcode is one the FSM sequences (R-type also needs a known funct).
  always_comb begin
    case (opcode)
      OP_RTYPE:                          legal = r_ok;
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
      default:                           legal = i_ok;
    endcase
  end

  // Pick the ALU operation the current state needs; idle states park on AND (all zeros).
  always_comb begin
    case (state)
      FETCH, DECODE, MEM_ADR: alu_ctrl = ALU_ADD;
      EXEC_R:                 alu_ctrl = r_ctrl;
      EXEC_I:                 alu_ctrl = i_ctrl;
      BRANCH:                 alu_ctrl = ALU_SUB;
      default:                alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: one state per cycle, memory-ready stalls.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic                   clk,
  input  logic                   rstb,
  mips_multicycle_ctrl_if.master bus
);

  state_t           state_reg;
  state_t           state_next;
  logic             mem_ready_q;
  logic             instr_legal;
  logic [ALU_W-1:0] alu_ctrl_dec;

  // With waiting disabled the memory is assumed to answer in a single cycle.
  assign mem_ready_q = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;

  mips_alu_decoder u_alu_dec (
    .state    (state_reg),
    .opcode   (bus.opcode),
    .funct    (bus.funct),
    .alu_ctrl (alu_ctrl_dec),
    .legal    (instr_legal)
  );

  assign bus.alu_ctrl  = alu_ctrl_dec;
  assign bus.state_dbg = state_reg;

  // State register; reset drops to RST_IDLE immediately, abandoning any instruction.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_reg <= RST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state sequencing, including memory stalls and opcode dispatch in DECODE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RST_IDLE: state_next = FETCH;
      FETCH:    if (mem_ready_q) state_next = DECODE;
      DECODE: begin
        if (!instr_legal) begin
          state_next = FETCH;
        end else begin
          case (bus.opcode)
            OP_RTYPE:                          state_next = EXEC_R;
            OP_LW, OP_SW:                      state_next = MEM_ADR;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = EXEC_I;
            OP_BEQ, OP_BNE:                    state_next = BRANCH;
            OP_J:                              state_next = JUMP;
            default:                           state_next = FETCH;
          endcase
        end
      end
      EXEC_R:   state_next = WB_R;
      WB_R:     state_next = FETCH;
      EXEC_I:   state_next = WB_I;
      WB_I:     state_next = FETCH;
      MEM_ADR:  state_next = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready_q) state_next = WB_MEM;
      WB_MEM:   state_next = FETCH;
      MEM_WR:   if (mem_ready_q) state_next = FETCH;
      BRANCH:   state_next = FETCH;
      JUMP:     state_next = FETCH;
      default:  state_next = RST_IDLE;
    endcase
  end

  // Datapath strobes and selects decoded from the current state (all zero unless set).
  always_comb begin
    bus.pc_en         = 1'b0;
    bus.pc_src        = PCSRC_ALU;
    bus.iord          = 1'b0;
    bus.mem_rd        = 1'b0;
    bus.mem_wr        = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.alu_src_a     = SRCA_PC;
    bus.alu_src_b     = SRCB_RT;
    bus.illegal_instr = 1'b0;
    case (state_reg)
      FETCH: begin
        bus.mem_rd    = 1'b1;
        bus.ir_write  = mem_ready_q;
        bus.pc_en     = mem_ready_q;
        bus.alu_src_b = SRCB_FOUR;
      end
      DECODE: begin
        bus.alu_src_b     = SRCB_IMM_SH2;
        bus.illegal_instr = ~instr_legal;
      end
      EXEC_R: begin
        bus.alu_src_a = is_shift(bus.funct) ? SRCA_SHAMT : SRCA_RS;
        bus.alu_src_b = SRCB_RT;
      end
      WB_R: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      EXEC_I, MEM_ADR: begin
        bus.alu_src_a = SRCA_RS;
        bus.alu_src_b = SRCB_IMM;
      end
      WB_I: bus.reg_write = 1'b1;
      MEM_RD: begin
        bus.mem_rd = 1'b1;
        bus.iord   = 1'b1;
      end
      WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        bus.mem_wr = 1'b1;
        bus.iord   = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a = SRCA_RS;
        bus.alu_src_b = SRCB_RT;
        bus.pc_src    = PCSRC_ALUOUT;
        bus.pc_en     = (bus.opcode == OP_BNE) ? ~bus.alu_zero : bus.alu_zero;
      end
      JUMP: begin
        bus.pc_src = PCSRC_JUMP;
        bus.pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed scenarios plus random instruction stream.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus();

  mips_multicycle_ctrl #(.MEM_WAIT_EN(1)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Instruction classes, derived from the opcode/funct tables
  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BR = 5, K_J = 6;

  // State numbers as exported on state_dbg
  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_WB_R = 4,
                 S_EXEC_I = 5, S_WB_I = 6, S_MEM_ADR = 7, S_MEM_RD = 8, S_WB_MEM = 9,
                 S_MEM_WR = 10, S_BRANCH = 11, S_JUMP = 12;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic       zero;
  } cyc_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic cyc_t mk(input int st, input logic rdy, input logic zero);
    cyc_t c;
    c.st   = 4'(st);
    c.rdy  = rdy;
    c.zero = zero;
    return c;
  endfunction

  function automatic int klass(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02}) ? K_R : K_ILL;
      6'h08, 6'h0C, 6'h0D, 6'h0A: return K_I;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04, 6'h05: return K_BR;
      6'h02: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic int exp_alu(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h20: return 2;
        6'h22: return 6;
        6'h24: return 0;
        6'h25: return 1;
        6'h2A: return 7;
        6'h00: return 8;
        6'h02: return 9;
        default: return 0;
      endcase
    end
    case (op)
      6'h08: return 2;
      6'h0C: return 0;
      6'h0D: return 1;
      6'h0A: return 7;
      6'h04, 6'h05: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] outs_vec();
    return 32'({bus.pc_en, bus.pc_src, bus.iord, bus.mem_rd, bus.mem_wr, bus.ir_write,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                bus.alu_ctrl, bus.illegal_instr});
  endfunction

  // Run one instruction starting in FETCH (caller is #1 after the edge that entered FETCH).
  // sf / sm = stall cycles in FETCH / in the data memory state; z = alu_zero in BRANCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int sf, input int sm);
    cyc_t plan[$];
    int k, rd_cnt, wr_cnt, iord_cnt, rw_cnt, pc_cnt, ir_cnt, ill_cnt, conf;
    logic taken;
    logic [31:0] ex_alu, ex_a, ex_b, wb_dst, wb_m2r, br_src;
    k = klass(op, fn);
    rd_cnt = 0; wr_cnt = 0; iord_cnt = 0; rw_cnt = 0; pc_cnt = 0; ir_cnt = 0;
    ill_cnt = 0; conf = 0;
    ex_alu = '1; ex_a = '1; ex_b = '1; wb_dst = '1; wb_m2r = '1; br_src = '1;
    taken = (op == 6'h04) ? z : ~z;

    for (int i = 0; i < sf; i++) plan.push_back(mk(S_FETCH, 1'b0, rnd()));
    plan.push_back(mk(S_FETCH, 1'b1, rnd()));
    plan.push_back(mk(S_DECODE, rnd(), rnd()));
    case (k)
      K_R: begin plan.push_back(mk(S_EXEC_R, rnd(), rnd())); plan.push_back(mk(S_WB_R, rnd(), rnd())); end
      K_I: begin plan.push_back(mk(S_EXEC_I, rnd(), rnd())); plan.push_back(mk(S_WB_I, rnd(), rnd())); end
      K_LW: begin
        plan.push_back(mk(S_MEM_ADR, rnd(), rnd()));
        for (int i = 0; i < sm; i++) plan.push_back(mk(S_MEM_RD, 1'b0, rnd()));
        plan.push_back(mk(S_MEM_RD, 1'b1, rnd()));
        plan.push_back(mk(S_WB_MEM, rnd(), rnd()));
      end
      K_SW: begin
        plan.push_back(mk(S_MEM_ADR, rnd(), rnd()));
        for (int i = 0; i < sm; i++) plan.push_back(mk(S_MEM_WR, 1'b0, rnd()));
        plan.push_back(mk(S_MEM_WR, 1'b1, rnd()));
      end
      K_BR: plan.push_back(mk(S_BRANCH, rnd(), z));
      K_J:  plan.push_back(mk(S_JUMP, rnd(), rnd()));
      default: ;
    endcase

    bus.opcode = op;
    bus.funct  = fn;
    foreach (plan[i]) begin
      bus.mem_ready = plan[i].rdy;
      bus.alu_zero  = plan[i].zero;
      @(negedge clk);
      chk($sformatf("state op%0h cyc%0d", op, i), 32'(bus.state_dbg), 32'(plan[i].st));
      if (bus.mem_rd) rd_cnt++;
      if (bus.mem_wr) wr_cnt++;
      if (bus.iord) iord_cnt++;
      if (bus.pc_en) pc_cnt++;
      if (bus.ir_write) ir_cnt++;
      if (bus.illegal_instr) ill_cnt++;
      if (int'(bus.mem_rd) + int'(bus.mem_wr) + int'(bus.reg_write) > 1) conf++;
      if (bus.reg_write) begin
        rw_cnt++;
        wb_dst = 32'(bus.reg_dst);
        wb_m2r = 32'(bus.mem_to_reg);
      end
      if (plan[i].st inside {4'(S_EXEC_R), 4'(S_EXEC_I), 4'(S_BRANCH)}) begin
        ex_alu = 32'(bus.alu_ctrl);
        ex_a   = 32'(bus.alu_src_a);
        ex_b   = 32'(bus.alu_src_b);
      end
      if (plan[i].st inside {4'(S_BRANCH), 4'(S_JUMP)}) br_src = 32'(bus.pc_src);
      @(posedge clk);
      #1;
    end

    chk($sformatf("mem_rd_cycles op%0h", op), 32'(rd_cnt), 32'(sf + 1 + ((k == K_LW) ? sm + 1 : 0)));
    chk($sformatf("mem_wr_cycles op%0h", op), 32'(wr_cnt), 32'((k == K_SW) ? sm + 1 : 0));
    chk($sformatf("iord_cycles op%0h", op), 32'(iord_cnt), 32'((k == K_LW || k == K_SW) ? sm + 1 : 0));
    chk($sformatf("reg_write_cycles op%0h", op), 32'(rw_cnt), 32'((k == K_R || k == K_I || k == K_LW) ? 1 : 0));
    chk($sformatf("pc_en_cycles op%0h", op), 32'(pc_cnt),
        32'(1 + ((k == K_J) ? 1 : 0) + ((k == K_BR && taken) ? 1 : 0)));
    chk($sformatf("ir_write_cycles op%0h", op), 32'(ir_cnt), 32'd1);
    chk($sformatf("illegal_cycles op%0h fn%0h", op, fn), 32'(ill_cnt), 32'((k == K_ILL) ? 1 : 0));
    chk($sformatf("strobe_overlap op%0h", op), 32'(conf), 32'd0);
    if (k == K_R || k == K_I || k == K_BR) begin
      chk($sformatf("alu_ctrl op%0h fn%0h", op, fn), ex_alu, 32'(exp_alu(op, fn)));
      chk($sformatf("alu_src_a op%0h", op), ex_a,
          32'((k == K_R && (fn == 6'h00 || fn == 6'h02)) ? 2 : 1));
      chk($sformatf("alu_src_b op%0h", op), ex_b, 32'((k == K_I) ? 2 : 0));
    end
    if (k == K_R || k == K_I || k == K_LW) begin
      chk($sformatf("reg_dst op%0h", op), wb_dst, 32'((k == K_R) ? 1 : 0));
      chk($sformatf("mem_to_reg op%0h", op), wb_m2r, 32'((k == K_LW) ? 1 : 0));
    end
    if (k == K_BR || k == K_J) chk($sformatf("pc_src op%0h", op), br_src, 32'((k == K_J) ? 2 : 1));
    $display("instr op=%02h fn=%02h zero=%0d fetch_stall=%0d mem_stall=%0d cycles=%0d",
             op, fn, z, sf, sm, plan.size());
  endtask

  // Watchdog: the run is a bounded sequence of clock edges, so this only fires on a hang.
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [5:0] op_tab [12];
  logic [5:0] fn_tab [8];

  initial begin
    op_tab = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h04, 6'h05, 6'h02, 6'h3F};
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h21};
    bus.opcode = 6'h00;
    bus.funct = 6'h20;
    bus.alu_zero = 1'b1;
    bus.mem_ready = 1'b1;

    // Reset held 5 cycles: everything zero, state RST_IDLE
    rstb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("reset_outs cyc%0d", i), outs_vec(), 32'd0);
      chk($sformatf("reset_state cyc%0d", i), 32'(bus.state_dbg), 32'd0);
    end
    @(posedge clk);
    #1 rstb = 1'b1;
    @(negedge clk);
    chk("idle_before_edge", 32'(bus.state_dbg), 32'd0);
    @(posedge clk);
    #1;
    chk("fetch_after_release", 32'(bus.state_dbg), 32'd1);
    chk("fetch_mem_rd", 32'(bus.mem_rd), 32'd1);

    // Directed instructions
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);   // add
    run_instr(6'h23, 6'h00, 1'b0, 0, 3);   // lw, 3 stall cycles in MEM_RD
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
    run_instr(6'h05, 6'h00, 1'b1, 0, 0);   // bne not taken
    run_instr(6'h05, 6'h00, 1'b0, 0, 0);   // bne taken
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);   // illegal opcode
    run_instr(6'h2B, 6'h00, 1'b0, 2, 2);   // sw with fetch and write stalls
    run_instr(6'h02, 6'h00, 1'b0, 0, 0);   // j

    // Random instruction stream
    for (int n = 0; n < 60; n++) begin
      run_instr(op_tab[$urandom_range(0, 11)], fn_tab[$urandom_range(0, 7)], rnd(),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset asserted mid-stall in MEM_WR
    bus.opcode = 6'h2B;
    bus.funct = 6'h00;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;                    // DECODE
    @(posedge clk); #1;                    // MEM_ADR
    @(posedge clk); #1;                    // MEM_WR
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("memwr_stall_state", 32'(bus.state_dbg), 32'd10);
    chk("memwr_stall_strobe", 32'(bus.mem_wr), 32'd1);
    @(posedge clk); #1;                    // still stalled in MEM_WR
    chk("memwr_still_stalled", 32'(bus.mem_wr), 32'd1);
    #2 rstb = 1'b0;
    #1;
    chk("async_reset_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("async_reset_state", 32'(bus.state_dbg), 32'd0);
    chk("async_reset_outs", outs_vec(), 32'd0);
    $display("instr async reset during MEM_WR stall");
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1 rstb = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'(bus.state_dbg), 32'd0);
    @(posedge clk); #1;
    chk("post_reset_fetch", 32'(bus.state_dbg), 32'd1);
    run_instr(6'h00, 6'h22, 1'b0, 1, 0);   // sub after recovery

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
